// File: rtl/alu_seq.sv
// alu_seq: responder side of the control-unit ALU handshake.
// Optional MUL/DIV (shift-add multiply, restoring divide) is built in when
// ALU_SEQ_MULDIV_EN is defined; without it, opcodes C/D act as reserved.
//
//   state | meaning
//   IDLE  | alu_done high, waiting for alu_executing
//   EXEC  | single-cycle op; result/flags registered on exit
//   RUN   | MUL/DIV iteration, cnt_q counts DATA_W-1 down to 0
module alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_executing,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              alu_done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v
);
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RUN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1} state_t;
`endif

  state_t state_q, state_d;
  logic              done_q, done_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] res_q, res_d, hi_q, hi_d;
  logic              z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

  logic              cin_eff;
  logic [DATA_W:0]   add_u, sub_u;
  logic [DATA_W-1:0] ex_res, ex_hi;
  logic              ex_z, ex_c, ex_n, ex_v;
  logic              long_start;

`ifdef ALU_SEQ_MULDIV_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
  logic [DATA_W:0]     mul_sum, div_sh;
  logic                div_borrow;
  logic [DATA_W-1:0]   div_rem;
`endif

  assign cin_eff = ((op_q == OP_ADC) || (op_q == OP_SBC)) & cin_q;
  assign add_u   = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, cin_eff};
  assign sub_u   = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, cin_eff};

`ifdef ALU_SEQ_MULDIV_EN
  // Divide-by-zero never enters RUN; it completes as a single-cycle op.
  assign long_start = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  // One iteration step: MUL shifts the product right, DIV shifts the remainder left.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? a_q : {DATA_W{1'b0}})};
    div_sh     = {acc_q[2*DATA_W-1:DATA_W], acc_q[MSB]};
    div_borrow = div_sh < {1'b0, b_q};
    div_rem    = div_borrow ? div_sh[MSB:0] : DATA_W'(div_sh - {1'b0, b_q});
    if (op_q == OP_MUL) acc_step = {mul_sum, acc_q[MSB:1]};
    else                acc_step = {div_rem, acc_q[MSB-1:0], ~div_borrow};
  end
`else
  assign long_start = 1'b0;
`endif

  // Single-cycle result and flags from the captured operands.
  always_comb begin
    ex_res = '0;
    ex_hi  = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        ex_res = add_u[MSB:0];
        ex_c   = add_u[DATA_W];
        ex_v   = (a_q[MSB] == b_q[MSB]) && (add_u[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        ex_res = sub_u[MSB:0];
        ex_c   = sub_u[DATA_W];
        ex_v   = (a_q[MSB] != b_q[MSB]) && (sub_u[MSB] != a_q[MSB]);
      end
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_NOT:  ex_res = ~a_q;
      OP_SHL: begin
        ex_res = {a_q[MSB-1:0], 1'b0};
        ex_c   = a_q[MSB];
      end
      OP_SHR: begin
        ex_res = {1'b0, a_q[MSB:1]};
        ex_c   = a_q[0];
      end
      OP_PASS: ex_res = b_q;
`ifdef ALU_SEQ_MULDIV_EN
      OP_DIV: begin
        ex_res = '1;
        ex_hi  = a_q;
        ex_v   = 1'b1;
      end
`endif
      default: ;
    endcase
    ex_z = (ex_res == '0);
    ex_n = ex_res[MSB];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (alu_executing) begin
`ifdef ALU_SEQ_MULDIV_EN
        state_d = long_start ? S_RUN : S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: state_d = S_IDLE;
`ifdef ALU_SEQ_MULDIV_EN
      S_RUN:  if (cnt_q == '0) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on start, publish only when alu_done rises.
  always_comb begin
    done_d = done_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    cin_d  = cin_q;
    res_d  = res_q;
    hi_d   = hi_q;
    z_d    = z_q;
    c_d    = c_q;
    n_d    = n_q;
    v_d    = v_q;
`ifdef ALU_SEQ_MULDIV_EN
    cnt_d  = cnt_q;
    acc_d  = acc_q;
`endif
    case (state_q)
      S_IDLE: if (alu_executing) begin
        op_d   = op;
        a_d    = a;
        b_d    = b;
        cin_d  = cin;
        done_d = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        cnt_d  = CNT_W'(DATA_W - 1);
        acc_d  = (op == OP_MUL) ? {{DATA_W{1'b0}}, b} : {{DATA_W{1'b0}}, a};
`endif
      end
      S_EXEC: begin
        done_d = 1'b1;
        if (op_q != OP_CMP) begin
          res_d = ex_res;
          hi_d  = ex_hi;
        end
        z_d = ex_z;
        c_d = ex_c;
        n_d = ex_n;
        v_d = ex_v;
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          done_d = 1'b1;
          res_d  = acc_step[MSB:0];
          hi_d   = acc_step[2*DATA_W-1:DATA_W];
          z_d    = (acc_step[MSB:0] == '0);
          n_d    = acc_step[MSB];
          c_d    = (op_q == OP_MUL) && (acc_step[2*DATA_W-1:DATA_W] != '0);
          v_d    = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q   <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign alu_done  = done_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes reference-model expectations,
// a monitor pops and compares on every alu_done rising edge.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, alu_executing, cin;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         alu_done, flag_z, flag_c, flag_n, flag_v;

  alu_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .alu_executing(alu_executing), .op(op), .a(a), .b(b),
    .cin(cin), .alu_done(alu_done), .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int hi; int z; int c; int n; int v; int lat; int op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   m_res = 0, m_hi = 0;
  int   rises = 0, cyc = 0, t_fall = 0;
  bit   mon_en = 1'b0;
  logic done_prev = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic exp_t model(input int o, input int x, input int y, input int ci);
    exp_t e;
    int t, s;
    e.op = o; e.lat = 1; e.r = 0; e.hi = 0; e.c = 0; e.v = 0;
    case (o)
      0, 1: begin
        t = x + y + ((o == 1) ? ci : 0);
        s = sx(x) + sx(y) + ((o == 1) ? ci : 0);
        e.r = t % 256; e.c = int'(t > 255); e.v = int'(s > 127 || s < -128);
      end
      2, 3, 10: begin
        t = x - y - ((o == 3) ? ci : 0);
        s = sx(x) - sx(y) - ((o == 3) ? ci : 0);
        e.r = (t + 256) % 256; e.c = int'(t < 0); e.v = int'(s > 127 || s < -128);
      end
      4: e.r = x & y;
      5: e.r = x | y;
      6: e.r = x ^ y;
      7: e.r = 255 - x;
      8: begin e.r = (x * 2) % 256; e.c = int'(x >= 128); end
      9: begin e.r = x / 2; e.c = x % 2; end
      11: e.r = y;
`ifdef ALU_SEQ_MULDIV_EN
      12: begin
        t = x * y; e.r = t % 256; e.hi = t / 256; e.c = int'(e.hi != 0); e.lat = 8;
      end
      13: begin
        if (y == 0) begin e.r = 255; e.hi = x; e.v = 1; end
        else begin e.r = x / y; e.hi = x % y; e.lat = 8; end
      end
`endif
      default: ;
    endcase
    e.z = int'(e.r == 0);
    e.n = int'(e.r >= 128);
    if (o == 10) begin e.r = m_res; e.hi = m_hi; end
    return e;
  endfunction

  // Monitor: compare on every rising edge of alu_done, measure latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (done_prev && !alu_done) t_fall = cyc;
        if (!done_prev && alu_done) begin
          rises++;
          if (sb.size() == 0) begin
            chk("unexpected done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("op%0h result", e.op), int'(result), e.r);
            chk($sformatf("op%0h result_hi", e.op), int'(result_hi), e.hi);
            chk($sformatf("op%0h Z", e.op), int'(flag_z), e.z);
            chk($sformatf("op%0h C", e.op), int'(flag_c), e.c);
            chk($sformatf("op%0h N", e.op), int'(flag_n), e.n);
            chk($sformatf("op%0h V", e.op), int'(flag_v), e.v);
            chk($sformatf("op%0h latency", e.op), cyc - t_fall, e.lat);
          end
        end
      end
      done_prev = alu_done;
    end
  end

  // Issue one op (called at a negedge with the DUT idle); returns at the
  // negedge where alu_done is seen high again.
  task automatic do_op(input int o, input int x, input int y, input int ci,
                       input bit hold, input bit toggle);
    exp_t e;
    bit seen;
    seen = 1'b0;
    op = 4'(o); a = 8'(x); b = 8'(y); cin = 1'(ci);
    alu_executing = 1'b1;
    e = model(o, x, y, ci);
    sb.push_back(e);
    m_res = e.r; m_hi = e.hi;
    @(posedge clk); #1;
    if (!hold) alu_executing = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (alu_done) seen = 1'b1;
      else if (toggle) alu_executing = ~alu_executing;
    end
    if (toggle) alu_executing = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done timeout op%0h: got no done expected done within 30 cycles", o);
    end
  endtask

  // Start an op, then reset after 'busy' extra cycles; no result must appear.
  task automatic reset_mid(input int o, input int x, input int y, input int busy);
    int bad;
    mon_en = 1'b0;
    op = 4'(o); a = 8'(x); b = 8'(y); cin = 1'b0;
    alu_executing = 1'b1;
    @(posedge clk); #1;
    alu_executing = 1'b0;
    chk("busy before reset", int'(alu_done), 0);
    repeat (busy) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset mid done", int'(alu_done), 1);
    chk("reset mid result", int'(result), 0);
    chk("reset mid result_hi", int'(result_hi), 0);
    chk("reset mid flags", int'({flag_z, flag_c, flag_n, flag_v}), 0);
    @(negedge clk); rst = 1'b1;
    m_res = 0; m_hi = 0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!alu_done || result != 0) bad++;
    end
    chk("after abort idle", bad, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    int r0;
    rst = 1'b0; alu_executing = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset done", int'(alu_done), 1);
    chk("reset result", int'(result), 0);
    chk("reset result_hi", int'(result_hi), 0);
    chk("reset flags", int'({flag_z, flag_c, flag_n, flag_v}), 0);
    @(negedge clk); rst = 1'b1;
    mon_en = 1'b1;

    do_op(0,  'h7F, 'h01, 0, 0, 0);
    do_op(2,  'h10, 'h20, 0, 0, 0);
    do_op(10, 'h05, 'h05, 0, 0, 0);
    do_op(12, 'hFF, 'hFF, 0, 0, 1);
    do_op(13, 'h64, 'h07, 0, 0, 0);
    do_op(13, 'h33, 'h00, 0, 0, 0);
    do_op(1,  'hFF, 'h00, 1, 0, 0);
    do_op(3,  'h00, 'h7F, 1, 0, 0);
    do_op(14, 'h12, 'h34, 1, 0, 0);

    r0 = rises;
    do_op(0, 'h11, 'h22, 0, 1, 0);
    do_op(8, 'h81, 'h00, 0, 1, 0);
    do_op(6, 'hF0, 'h3C, 0, 0, 0);
    @(negedge clk);
    chk("back-to-back rises", rises - r0, 3);

    for (int i = 0; i < 80; i++) begin
      int o, x, y;
      o = int'($urandom_range(0, 15));
      x = int'($urandom_range(0, 255));
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      do_op(o, x, y, int'($urandom_range(0, 1)), 0, 0);
    end

`ifdef ALU_SEQ_MULDIV_EN
    reset_mid(12, 'hFF, 'hFF, 3);
`else
    reset_mid(0, 'h12, 'h34, 0);
`endif
    do_op(5, 'hA0, 'h05, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Responder side of the control-unit ALU handshake: samples a start request on `alu_executing`, executes one ALU operation, and signals completion with a rising edge on `alu_done`.
- Single-cycle ops cover logic, add/sub and shift. MUL and DIV run as multi-cycle shift-add / restoring-division iterations.
- Sits between the register-file output muxes and the control unit.
- Result and flags are held stable from the `alu_done` rising edge until the next operation's completion.

Parameters:
- DATA_W, 8, operand/result width; MUL/DIV iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- alu_executing  input  1  start request from the control unit; level, sampled only when idle.
- alu_done  output  1  high when idle/finished; low while busy; a rising edge marks result valid.
- op  input  4  opcode, captured at start.
- a  input  DATA_W  operand A, captured at start.
- b  input  DATA_W  operand B, captured at start.
- cin  input  1  carry-in for ADC/SBC, captured at start.
- result  output  DATA_W  primary result.
- result_hi  output  DATA_W  MUL high half / DIV remainder; 0 for other ops.
- flag_z, flag_c, flag_n, flag_v  output  1 each  zero, carry/borrow, negative, signed overflow.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, alu_done=1, result=0, result_hi=0, all flags 0.
  - Reset mid-operation aborts the op with no result update.
- States and transitions:
  - IDLE: if alu_executing==1, capture op/a/b/cin, set alu_done<=0, go to EXEC (single-cycle op) or RUN (MUL/DIV).
  - EXEC: compute, register result/flags, set alu_done<=1, go to IDLE.
  - RUN: 3-bit iteration counter from DATA_W-1 down to 0. On the count-0 cycle, write result/flags, set alu_done<=1, go to IDLE.
- Latency, with the start sampled at edge N:
  - alu_done falls at N.
  - Single-cycle ops: alu_done rises at N+1.
  - MUL/DIV: alu_done rises at N+DATA_W (N+8 by default).
- alu_executing is ignored outside IDLE. A start is taken only in IDLE, so the done pulse never retriggers itself. alu_executing held high across completion starts a new op on the first IDLE cycle.
- Opcodes:
  - 0 ADD, 1 ADC(+cin), 2 SUB, 3 SBC(-cin).
  - 4 AND, 5 OR, 6 XOR, 7 NOT a.
  - 8 SHL a, 9 SHR a (logical).
  - A CMP: flags as SUB; result and result_hi unchanged.
  - B PASS b.
  - C MUL: unsigned; result=low half, result_hi=high half.
  - D DIV: unsigned; result=quotient, result_hi=remainder.
  - E/F reserved: result=0, flag_z=1, other flags 0, single-cycle.
- Flags:
  - Z = (result==0). N = result[DATA_W-1].
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB/SBC/CMP: C = borrow (1 when a < b+cin); V = signed overflow. For CMP, Z and N are computed from the difference.
  - Logic ops and PASS: C=0, V=0.
  - SHL: C = a[MSB]. SHR: C = a[0]. V=0 for both.
  - MUL: C = (result_hi!=0), V=0.
  - DIV: C=0, V=0.
- DIV by zero: detected at start, completes in EXEC at N+1, result=all-ones, result_hi=a, V=1, Z=0.
- All arithmetic is modulo 2^DATA_W.
- Outputs change only on the edge that raises alu_done.

Optional Feature:
- MUL/DIV support is compiled in or out with the macro ALU_SEQ_MULDIV_EN.
- Defined: MUL/DIV execute as specified above, via RUN.
- Undefined:
  - RUN state and iteration datapath are removed.
  - Opcodes C/D behave as reserved: single-cycle, result=0, result_hi=0, flag_z=1.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then 1 -> alu_done=1, result=0, all flags 0. Assert reset during MUL cycle 4 -> alu_done=1 next edge, result stays 0.
- ADD a=0x7F b=0x01 -> alu_done low exactly 1 cycle; result=0x80, N=1, V=1, C=0, Z=0.
- SUB a=0x10 b=0x20 -> result=0xF0, C=1, N=1. Then CMP a=0x05 b=0x05 -> Z=1, C=0, result still 0xF0.
- MUL a=0xFF b=0xFF -> alu_done rises exactly 8 cycles after start; result=0x01, result_hi=0xFE, C=1. alu_executing toggled mid-run is ignored.
- DIV a=0x64 b=0x07 -> after 8 cycles result=0x0E, result_hi=0x02. DIV a=0x33 b=0x00 -> done at N+1, result=0xFF, result_hi=0x33, V=1.
- Back-to-back: alu_executing held high over 3 ops (ADD, SHL a=0x81, XOR) -> 3 distinct done rising edges. SHL gives result=0x02, C=1. Without ALU_SEQ_MULDIV_EN, op C -> result=0, Z=1, done at N+1.
